pc_fetch_unit: RTL

//  Program counter and instruction-fetch stage of the AVR-style RISC core.

---
 rtl/avr_core_pkg.sv | 8 +
 rtl/pc_fetch_unit_if.sv | 13 +
 rtl/pc_next_mux.sv | 11 +
 rtl/pc_fetch_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/avr_core_pkg.sv
// Shared AVR core definitions: fetch FSM state encoding and opcode constants.
package avr_core_pkg;
    localparam int OPCODE_W = 6;
    localparam logic [OPCODE_W-1:0] OPC_JMP  = 6'b110000;
    localparam logic [OPCODE_W-1:0] OPC_HALT = 6'b111111;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} fetch_state_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: req/addr from the fetch unit, ack/rdata from memory.
interface pc_fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_next_mux.sv
// Next-PC select: sequential PC+1 (wraps modulo 2**PC_W) or the jump target verbatim.
module pc_next_mux #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic            pc_src,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc_next
);
    assign pc_next = pc_src ? pc + PC_W'(1) : jump_target;
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and instruction register of the AVR-style core.
// Optional HALT state enabled by defining PC_HALT_EN.
module pc_fetch_unit
    import avr_core_pkg::*;
#(
    parameter int              PC_W      = 10,
    parameter int              INSTR_W   = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_src,
    input  logic [PC_W-1:0]     jump_target,
    input  logic                stall,
    pc_fetch_unit_if.master     imem,
    output logic [INSTR_W-1:0]  ireg_out,
    output logic [OPCODE_W-1:0] opcode,
    output logic                ireg_valid,
    output logic [PC_W-1:0]     pc_out
);
    fetch_state_t       state, state_nxt;
    logic [PC_W-1:0]    pc, pc_nxt, pc_sel;
    logic [INSTR_W-1:0] ireg, ireg_nxt;
    logic               valid, valid_nxt;
    logic               req, req_nxt;
    logic               halt_op;

    pc_next_mux #(.PC_W(PC_W)) u_pc_next_mux (
        .pc          (pc),
        .pc_src      (pc_src),
        .jump_target (jump_target),
        .pc_next     (pc_sel)
    );

`ifdef PC_HALT_EN
    assign halt_op = (opcode == OPC_HALT);
`else
    assign halt_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_VEC;
            ireg  <= '0;
            valid <= 1'b0;
            req   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ireg  <= ireg_nxt;
            valid <= valid_nxt;
            req   <= req_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ireg_nxt  = ireg;
        valid_nxt = valid;
        req_nxt   = req;
        case (state)
            FETCH: begin
                // req is low for the first cycle after reset, so a stale ack is dropped
                req_nxt = 1'b1;
                if (req && imem.imem_ack) begin
                    ireg_nxt  = imem.imem_rdata;
                    valid_nxt = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (halt_op) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = pc_sel;
                        valid_nxt = 1'b0;
                        req_nxt   = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign ireg_out       = ireg;
    assign opcode         = ireg[INSTR_W-1 -: OPCODE_W];
    assign ireg_valid     = valid;
    assign pc_out         = pc;
endmodule
